ddram_rom_ctrl: RTL and testbench

DDRAM_ROM_CTRL -- requirements
Module: ddram_rom_ctrl

---
 rtl/ddram_rom_ctrl.sv | 144 ++++++++++++++
 tb/tb_ddram_rom_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_rom_ctrl.sv
// rtl/ddram_rom_ctrl.sv - 16-bit toggle-handshake ROM port onto a 64-bit DDRAM bus with a one-line read cache
module ddram_rom_ctrl #(
    parameter logic [6:0] BASE_ADDR = 7'h18
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic [24:0] wraddr,
    input  logic [15:0] din,
    input  logic        we_req,
    output logic        we_ack,

    input  logic [22:0] rdaddr,
    output logic [15:0] dout,
    input  logic        rd_req,
    output logic        rd_ack,

    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WRITE   = 2'd1;
    localparam logic [1:0] S_RD_CMD  = 2'd2;
    localparam logic [1:0] S_RD_WAIT = 2'd3;

    logic [1:0]  r_state;
    logic        r_we_ack;
    logic        r_rd_ack;
    logic [15:0] r_dout;
    logic        r_rd;
    logic        r_we;
    logic [28:0] r_addr;
    logic [63:0] r_din;
    logic [7:0]  r_be;
    logic [63:0] r_line;
    logic [21:0] r_tag;
    logic        r_valid;

    logic        w_wr_pend;
    logic        w_rd_pend;
    logic [21:0] w_rd_tag;
    logic        w_hit;
    logic [15:0] w_hit_word;
    logic [15:0] w_ret_word;
    logic        w_unused_wraddr0;

    // Byte address bit 0 carries no information for 16-bit writes.
    assign w_unused_wraddr0 = wraddr[0];

    assign w_wr_pend  = (we_req != r_we_ack);
    assign w_rd_pend  = (rd_req != r_rd_ack);
    assign w_rd_tag   = {1'b0, rdaddr[22:2]};
    assign w_hit      = r_valid && (r_tag == w_rd_tag);
    assign w_hit_word = r_line[{rdaddr[1:0], 4'b0000} +: 16];
    assign w_ret_word = DDRAM_DOUT[{rdaddr[1:0], 4'b0000} +: 16];

    assign we_ack         = r_we_ack;
    assign rd_ack         = r_rd_ack;
    assign dout           = r_dout;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = r_addr;
    assign DDRAM_RD       = r_rd;
    assign DDRAM_WE       = r_we;
    assign DDRAM_DIN      = r_din;
    assign DDRAM_BE       = r_be;

    // Command sequencer: one DDRAM command in flight, writes win ties, hits answer without the bus.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rd     <= 1'b0;
            r_we     <= 1'b0;
            r_valid  <= 1'b0;
            r_dout   <= 16'h0000;
            r_we_ack <= we_req;
            r_rd_ack <= rd_req;
            r_addr   <= 29'h0;
            r_din    <= 64'h0;
            r_be     <= 8'h00;
            r_line   <= 64'h0;
            r_tag    <= 22'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_pend) begin
                        r_we    <= 1'b1;
                        r_addr  <= {BASE_ADDR, wraddr[24:3]};
                        r_din   <= {4{din}};
                        r_be    <= 8'b0000_0011 << {wraddr[2:1], 1'b0};
                        r_state <= S_WRITE;
                    end else if (w_rd_pend) begin
                        if (w_hit) begin
                            r_dout   <= w_hit_word;
                            r_rd_ack <= rd_req;
                        end else begin
                            r_rd    <= 1'b1;
                            r_addr  <= {BASE_ADDR, 1'b0, rdaddr[22:2]};
                            r_state <= S_RD_CMD;
                        end
                    end
                end
                S_WRITE: begin
                    // Command registers stay frozen until the bus accepts.
                    if (!DDRAM_BUSY) begin
                        r_we     <= 1'b0;
                        r_we_ack <= we_req;
                        if (wraddr[24:3] == r_tag) begin
                            r_valid <= 1'b0;
                        end
                        r_state  <= S_IDLE;
                    end
                end
                S_RD_CMD: begin
                    if (!DDRAM_BUSY) begin
                        r_rd    <= 1'b0;
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        r_line   <= DDRAM_DOUT;
                        r_tag    <= w_rd_tag;
                        r_valid  <= 1'b1;
                        r_dout   <= w_ret_word;
                        r_rd_ack <= rd_req;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_rom_ctrl.sv
// tb/tb_ddram_rom_ctrl.sv - scoreboard bench for ddram_rom_ctrl
module tb_ddram_rom_ctrl;

    localparam logic [6:0] BASE = 7'h18;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [24:0] wraddr;
    logic [15:0] din;
    logic        we_req;
    logic        we_ack;
    logic [22:0] rdaddr;
    logic [15:0] dout;
    logic        rd_req;
    logic        rd_ack;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    always #5 clk_sys = ~clk_sys;

    ddram_rom_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .wraddr(wraddr), .din(din), .we_req(we_req), .we_ack(we_ack),
        .rdaddr(rdaddr), .dout(dout), .rd_req(rd_req), .rd_ack(rd_ack),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
        .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT),
        .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD),
        .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
    );

    typedef struct {
        bit          is_wr;
        logic [28:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } cmd_t;

    cmd_t        exp_q[$];
    cmd_t        act_q[$];
    logic [15:0] exp_dout_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          we_cycles = 0;
    int          overlap   = 0;

    function automatic logic [7:0] f_be(input logic [24:0] a);
        return 8'b0000_0011 << (2 * a[2:1]);
    endfunction

    function automatic logic [15:0] f_word(input logic [63:0] d, input logic [1:0] w);
        return d[16*w +: 16];
    endfunction

    // Accepted DDRAM commands observed on the bus, plus pulse/overlap bookkeeping.
    always @(posedge clk_sys) begin
        if (!reset && DDRAM_WE && !DDRAM_BUSY)
            act_q.push_back('{is_wr: 1'b1, addr: DDRAM_ADDR, data: DDRAM_DIN, be: DDRAM_BE});
        if (!reset && DDRAM_RD && !DDRAM_BUSY)
            act_q.push_back('{is_wr: 1'b0, addr: DDRAM_ADDR, data: 64'h0, be: 8'h00});
        if (DDRAM_WE) we_cycles <= we_cycles + 1;
        if (DDRAM_WE && DDRAM_RD) overlap <= overlap + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_wr(input logic [24:0] a, input logic [15:0] d);
        exp_q.push_back('{is_wr: 1'b1, addr: {BASE, a[24:3]}, data: {4{d}}, be: f_be(a)});
    endtask

    task automatic push_rd(input logic [22:0] a);
        exp_q.push_back('{is_wr: 1'b0, addr: {BASE, 1'b0, a[22:2]}, data: 64'h0, be: 8'h00});
    endtask

    task automatic pop_pair(output cmd_t e, output cmd_t a, output bit ok);
        ok = (exp_q.size() > 0) && (act_q.size() > 0);
        e = '{is_wr: 1'b0, addr: '0, data: '0, be: '0};
        a = '{is_wr: 1'b1, addr: 'x, data: 'x, be: 'x};
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (act_q.size() > 0) a = act_q.pop_front();
    endtask

    task automatic pop_dout(output logic [15:0] d);
        d = 16'hxxxx;
        if (exp_dout_q.size() > 0) d = exp_dout_q.pop_front();
    endtask

    task automatic wait_ack(input bit is_wr, input logic target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((is_wr ? we_ack : rd_ack) === target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
    endtask

    task automatic serve_read(input logic [63:0] data, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (DDRAM_RD === 1'b1 && DDRAM_BUSY === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
        if (ok) begin
            @(negedge clk_sys);
            DDRAM_DOUT       = data;
            DDRAM_DOUT_READY = 1'b1;
            @(negedge clk_sys);
            DDRAM_DOUT_READY = 1'b0;
            DDRAM_DOUT       = 64'hDEAD_DEAD_DEAD_DEAD;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; we_req = 1'b1; rd_req = 1'b0;
        wraddr = '0; din = '0; rdaddr = '0;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT = 64'hDEAD_DEAD_DEAD_DEAD; DDRAM_DOUT_READY = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        n_checks++; if (we_ack !== 1'b1) begin n_fail++; $display("FAIL reset_we_ack: got %b want 1", we_ack); end
        n_checks++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ack: got %b want 0", rd_ack); end
        n_checks++; if (DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0) begin n_fail++; $display("FAIL reset_cmd: got rd=%b we=%b want 0 0", DDRAM_RD, DDRAM_WE); end
        n_checks++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h want 0000", dout); end
        n_checks++; if (DDRAM_BURSTCNT !== 8'd1) begin n_fail++; $display("FAIL burstcnt: got %h want 01", DDRAM_BURSTCNT); end
        DDRAM_DOUT_READY = 1'b1;
        @(negedge clk_sys);
        DDRAM_DOUT_READY = 1'b0;
        @(negedge clk_sys);
        n_checks++; if (rd_ack !== 1'b0 || dout !== 16'h0000) begin n_fail++; $display("FAIL stray_ready: got ack=%b dout=%h want 0 0000", rd_ack, dout); end
        n_checks++; if (act_q.size() != 0 || DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got %0d cmds rd=%b we=%b want 0 0 0", act_q.size(), DDRAM_RD, DDRAM_WE); end
    endtask

    task automatic test_write();
        cmd_t e, a; bit ok, pok; int start;
        wraddr = 25'h00000A; din = 16'hBEEF;
        push_wr(wraddr, din);
        start = we_cycles;
        we_req = ~we_req;
        @(negedge clk_sys);
        wait_ack(1'b1, we_req, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL write_ack: got we_ack=%b want %b", we_ack, we_req); end
        @(negedge clk_sys);
        n_checks++; if (we_cycles - start != 1) begin n_fail++; $display("FAIL write_pulse: got %0d WE cycles want 1", we_cycles - start); end
        pop_pair(e, a, pok);
        n_checks++;
        if (!pok || !a.is_wr || a.addr !== e.addr || a.data !== e.data || a.be !== e.be) begin
            n_fail++;
            $display("FAIL write_cmd: got wr=%b addr=%h din=%h be=%h want wr=1 addr=%h din=%h be=%h",
                     a.is_wr, a.addr, a.data, a.be, e.addr, e.data, e.be);
        end
    endtask

    task automatic test_read_miss_hit();
        cmd_t e, a; bit ok, pok; logic [15:0] xd; logic [63:0] data; int n;
        data = 64'h4444_3333_2222_1111;
        rdaddr = 23'h0;
        push_rd(rdaddr);
        exp_dout_q.push_back(f_word(data, rdaddr[1:0]));
        rd_req = ~rd_req;
        serve_read(data, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL miss_rd_issue: got no DDRAM_RD want one"); end
        wait_ack(1'b0, rd_req, 10, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL miss_ack: got rd_ack=%b want %b", rd_ack, rd_req); end
        pop_dout(xd);
        n_checks++; if (dout !== xd) begin n_fail++; $display("FAIL miss_dout: got %h want %h", dout, xd); end
        pop_pair(e, a, pok);
        n_checks++; if (!pok || a.is_wr || a.addr !== e.addr) begin n_fail++; $display("FAIL miss_cmd: got wr=%b addr=%h want wr=0 addr=%h", a.is_wr, a.addr, e.addr); end
        rdaddr = 23'h3;
        exp_dout_q.push_back(f_word(data, rdaddr[1:0]));
        n = act_q.size();
        rd_req = ~rd_req;
        @(negedge clk_sys);
        n_checks++; if (rd_ack !== rd_req) begin n_fail++; $display("FAIL hit_ack: got %b want %b", rd_ack, rd_req); end
        pop_dout(xd);
        n_checks++; if (dout !== xd) begin n_fail++; $display("FAIL hit_dout: got %h want %h", dout, xd); end
        @(negedge clk_sys);
        n_checks++; if (act_q.size() != n || DDRAM_RD !== 1'b0) begin n_fail++; $display("FAIL hit_no_bus: got %0d new cmds rd=%b want 0 0", act_q.size() - n, DDRAM_RD); end
    endtask

    task automatic test_backpressure();
        cmd_t e, a; bit ok, pok; logic [15:0] xd; logic [63:0] data; logic [28:0] xaddr; int bad;
        data = 64'hAAAA_BBBB_CCCC_DDDD;
        rdaddr = 23'h12345;
        xaddr = {BASE, 1'b0, rdaddr[22:2]};
        push_rd(rdaddr);
        exp_dout_q.push_back(f_word(data, rdaddr[1:0]));
        DDRAM_BUSY = 1'b1;
        rd_req = ~rd_req;
        @(negedge clk_sys);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (DDRAM_RD !== 1'b1 || DDRAM_ADDR !== xaddr) bad++;
            @(negedge clk_sys);
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles (rd=%b addr=%h) want 0 with addr %h", bad, DDRAM_RD, DDRAM_ADDR, xaddr); end
        DDRAM_BUSY = 1'b0;
        serve_read(data, 10, ok);
        wait_ack(1'b0, rd_req, 10, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_ack: got rd_ack=%b want %b", rd_ack, rd_req); end
        n_checks++; if (act_q.size() != 1) begin n_fail++; $display("FAIL bp_count: got %0d accepted reads want 1", act_q.size()); end
        pop_pair(e, a, pok);
        n_checks++; if (!pok || a.is_wr || a.addr !== e.addr) begin n_fail++; $display("FAIL bp_cmd: got wr=%b addr=%h want wr=0 addr=%h", a.is_wr, a.addr, e.addr); end
        pop_dout(xd);
        n_checks++; if (dout !== xd) begin n_fail++; $display("FAIL bp_dout: got %h want %h", dout, xd); end
    endtask

    task automatic test_simultaneous();
        cmd_t e, a; bit ok, ok2, pok; logic [15:0] xd; logic [63:0] data;
        data = 64'h1234_5678_9ABC_DEF0;
        rdaddr = 23'h12345;
        wraddr = {1'b0, rdaddr[22:2], 2'b01, 1'b0};
        din = 16'h5A5A;
        push_wr(wraddr, din);
        push_rd(rdaddr);
        exp_dout_q.push_back(f_word(data, rdaddr[1:0]));
        we_req = ~we_req;
        rd_req = ~rd_req;
        serve_read(data, 30, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sim_read_miss: got no DDRAM_RD after write want one"); end
        wait_ack(1'b1, we_req, 10, ok);
        wait_ack(1'b0, rd_req, 10, ok2);
        n_checks++; if (!ok || !ok2) begin n_fail++; $display("FAIL sim_acks: got we_ack=%b rd_ack=%b want %b %b", we_ack, rd_ack, we_req, rd_req); end
        pop_pair(e, a, pok);
        n_checks++; if (!pok || !a.is_wr || a.addr !== e.addr || a.data !== e.data || a.be !== e.be) begin
            n_fail++; $display("FAIL sim_first_wr: got wr=%b addr=%h be=%h want wr=1 addr=%h be=%h", a.is_wr, a.addr, a.be, e.addr, e.be);
        end
        pop_pair(e, a, pok);
        n_checks++; if (!pok || a.is_wr || a.addr !== e.addr) begin n_fail++; $display("FAIL sim_second_rd: got wr=%b addr=%h want wr=0 addr=%h", a.is_wr, a.addr, e.addr); end
        pop_dout(xd);
        n_checks++; if (dout !== xd) begin n_fail++; $display("FAIL sim_dout: got %h want %h", dout, xd); end
    endtask

    task automatic test_reset_in_rd_wait();
        cmd_t e, a; bit ok, pok; logic [15:0] xd; logic [63:0] data; logic saved;
        rdaddr = 23'h000200;
        saved = rd_ack;
        push_rd(rdaddr);
        rd_req = ~rd_req;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (DDRAM_RD === 1'b1 && DDRAM_BUSY === 1'b0) begin ok = 1'b1; break; end
            @(negedge clk_sys);
        end
        @(negedge clk_sys);
        reset = 1'b1;
        rd_req = saved;
        @(negedge clk_sys);
        reset = 1'b0;
        DDRAM_DOUT = 64'h7777_6666_5555_4444;
        DDRAM_DOUT_READY = 1'b1;
        @(negedge clk_sys);
        DDRAM_DOUT_READY = 1'b0;
        @(negedge clk_sys);
        n_checks++; if (!ok || rd_ack !== saved) begin n_fail++; $display("FAIL rst_no_ack: got rd_ack=%b want %b", rd_ack, saved); end
        n_checks++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL rst_dout: got %h want 0000", dout); end
        n_checks++; if (DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0) begin n_fail++; $display("FAIL rst_cmd: got rd=%b we=%b want 0 0", DDRAM_RD, DDRAM_WE); end
        pop_pair(e, a, pok);
        n_checks++; if (!pok || a.is_wr || a.addr !== e.addr) begin n_fail++; $display("FAIL rst_cmd_issued: got wr=%b addr=%h want wr=0 addr=%h", a.is_wr, a.addr, e.addr); end
        data = 64'h0F0F_1E1E_2D2D_3C3C;
        push_rd(rdaddr);
        exp_dout_q.push_back(f_word(data, rdaddr[1:0]));
        rd_req = ~rd_req;
        serve_read(data, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_cache_invalid: got hit want miss with DDRAM_RD"); end
        wait_ack(1'b0, rd_req, 10, ok);
        pop_pair(e, a, pok);
        n_checks++; if (!pok || a.is_wr || a.addr !== e.addr) begin n_fail++; $display("FAIL rst_refill_cmd: got wr=%b addr=%h want wr=0 addr=%h", a.is_wr, a.addr, e.addr); end
        pop_dout(xd);
        n_checks++; if (!ok || dout !== xd) begin n_fail++; $display("FAIL rst_refill_dout: got %h ack_ok=%b want %h", dout, ok, xd); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_miss_hit();
        test_backpressure();
        test_simultaneous();
        test_reset_in_rd_wait();
        repeat (2) @(negedge clk_sys);
        n_checks++; if (overlap != 0) begin n_fail++; $display("FAIL rd_we_overlap: got %0d cycles want 0", overlap); end
        n_checks++; if (act_q.size() != 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_cmds: got act=%0d exp=%0d want 0 0", act_q.size(), exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
